// File: rtl/regbank_write_port.sv
// Register bank write port fed by toggle-signalled write events from writeback.
// Two registered read ports, PC (r15) and CPSR visibility.
// Optional build macro REGBANK_WR_BYPASS_EN: a read of the index being committed on the
// same edge returns the new data instead of the pre-write value.
module regbank_write_port #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       NUM_REGS   = 16,
  parameter logic [DATA_W-1:0] CPSR_RESET = 32'h000000D3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] dataIn,
  input  logic [3:0]        addrIn,
  input  logic [DATA_W-1:0] cpsrIn,
  input  logic              triggerIn,
  output logic              ackOut,
  output logic              busyOut,
  input  logic              rdEn,
  input  logic [3:0]        rdAddr1,
  input  logic [3:0]        rdAddr2,
  output logic [DATA_W-1:0] rdData1,
  output logic [DATA_W-1:0] rdData2,
  output logic              rdValid,
  output logic [DATA_W-1:0] cpsrOut,
  output logic [DATA_W-1:0] pcOut,
  output logic              pcWriteOut
);

  localparam int unsigned PcIdx = 15;

  typedef enum logic [1:0] {StIdle, StCapture, StCommit} state_e;

  state_e            state_q, state_d;
  logic              trig_s1_q, trig_s2_q, trig_acc_q;
  logic [DATA_W-1:0] hold_data_q, hold_cpsr_q;
  logic [3:0]        hold_addr_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] cpsr_q;
  logic              ack_q, pc_write_q;
  logic [DATA_W-1:0] rd_data1_q, rd_data2_q;
  logic              rd_valid_q;

  logic              pending;
  logic              capture_en;
  logic              commit_en;
  logic [DATA_W-1:0] rd_val1, rd_val2;

  // Each level change of the synchronised trigger not yet accepted is one request.
  assign pending = trig_s2_q ^ trig_acc_q;

  // Next-state decode; capture and commit strobes follow the state transitions.
  always_comb begin
    state_d    = state_q;
    capture_en = 1'b0;
    commit_en  = 1'b0;
    case (state_q)
      StIdle: begin
        if (pending) begin
          state_d    = StCapture;
          capture_en = 1'b1;
        end
      end
      StCapture: begin
        // The write lands on this edge, giving the 4-edge trigger-to-ack latency;
        // COMMIT is the cycle in which the committed result (and pcWriteOut) is visible.
        state_d   = StCommit;
        commit_en = 1'b1;
      end
      StCommit: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Synchroniser, accepted-level flop, FSM state and holding registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      trig_s1_q   <= 1'b0;
      trig_s2_q   <= 1'b0;
      trig_acc_q  <= 1'b0;
      state_q     <= StIdle;
      hold_data_q <= '0;
      hold_cpsr_q <= '0;
      hold_addr_q <= '0;
    end else begin
      trig_s1_q <= triggerIn;
      trig_s2_q <= trig_s1_q;
      state_q   <= state_d;
      if (capture_en) begin
        trig_acc_q  <= trig_s2_q;
        hold_data_q <= dataIn;
        hold_cpsr_q <= cpsrIn;
        hold_addr_q <= addrIn;
      end
    end
  end

  // Commit: register write, CPSR update, ack toggle and PC-write strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      cpsr_q     <= CPSR_RESET;
      ack_q      <= 1'b0;
      pc_write_q <= 1'b0;
    end else begin
      pc_write_q <= commit_en && (hold_addr_q == 4'd15);
      if (commit_en) begin
        regs_q[hold_addr_q] <= hold_data_q;
        cpsr_q              <= hold_cpsr_q;
        ack_q               <= ~ack_q;
      end
    end
  end

`ifdef REGBANK_WR_BYPASS_EN
  // Forward the data being committed this edge to a read of the same index.
  always_comb begin
    rd_val1 = regs_q[rdAddr1];
    rd_val2 = regs_q[rdAddr2];
    if (commit_en && (hold_addr_q == rdAddr1)) rd_val1 = hold_data_q;
    if (commit_en && (hold_addr_q == rdAddr2)) rd_val2 = hold_data_q;
  end
`else
  // Reads see the pre-write contents on a same-edge collision.
  always_comb begin
    rd_val1 = regs_q[rdAddr1];
    rd_val2 = regs_q[rdAddr2];
  end
`endif

  // Registered read ports; data holds its last value when rdEn is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data1_q <= '0;
      rd_data2_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rdEn;
      if (rdEn) begin
        rd_data1_q <= rd_val1;
        rd_data2_q <= rd_val2;
      end
    end
  end

  assign ackOut     = ack_q;
  assign busyOut    = (state_q != StIdle);
  assign rdData1    = rd_data1_q;
  assign rdData2    = rd_data2_q;
  assign rdValid    = rd_valid_q;
  assign cpsrOut    = cpsr_q;
  assign pcOut      = regs_q[PcIdx];
  assign pcWriteOut = pc_write_q;

endmodule

// File: tb/tb_regbank_write_port.sv
// Self-checking bench for regbank_write_port: directed steps plus randomized
// writes/reads against a simple array model of the register bank.
module tb_regbank_write_port;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dataIn = '0;
  logic [3:0]  addrIn = '0;
  logic [31:0] cpsrIn = '0;
  logic        triggerIn = 1'b0;
  logic        ackOut, busyOut;
  logic        rdEn = 1'b0;
  logic [3:0]  rdAddr1 = '0, rdAddr2 = '0;
  logic [31:0] rdData1, rdData2;
  logic        rdValid;
  logic [31:0] cpsrOut, pcOut;
  logic        pcWriteOut;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [31:0] m_regs [16];
  logic [31:0] m_cpsr;
  logic        m_ack;

  regbank_write_port dut (
    .clk       (clk),
    .reset     (reset),
    .dataIn    (dataIn),
    .addrIn    (addrIn),
    .cpsrIn    (cpsrIn),
    .triggerIn (triggerIn),
    .ackOut    (ackOut),
    .busyOut   (busyOut),
    .rdEn      (rdEn),
    .rdAddr1   (rdAddr1),
    .rdAddr2   (rdAddr2),
    .rdData1   (rdData1),
    .rdData2   (rdData2),
    .rdValid   (rdValid),
    .cpsrOut   (cpsrOut),
    .pcOut     (pcOut),
    .pcWriteOut(pcWriteOut)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_cpsr = 32'h000000D3;
    m_ack  = 1'b0;
  endtask

  // Read two indices; data and rdValid checked after the sampling edge.
  task automatic do_read(input logic [3:0] a1, input logic [3:0] a2);
    rdEn = 1'b1; rdAddr1 = a1; rdAddr2 = a2;
    step();
    rdEn = 1'b0;
    check("rd_valid", {31'd0, rdValid}, 32'd1);
    check($sformatf("rd1_r%0d", a1), rdData1, m_regs[a1]);
    check($sformatf("rd2_r%0d", a2), rdData2, m_regs[a2]);
    step();
    check("rd_valid_drop", {31'd0, rdValid}, 32'd0);
  endtask

  // Toggle-signalled write; ack must toggle on exactly the 4th edge.
  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [31:0] c);
    addrIn = a; dataIn = d; cpsrIn = c;
    triggerIn = ~triggerIn;
    for (int e = 1; e <= 3; e++) begin
      step();
      check($sformatf("ack_hold_e%0d", e), {31'd0, ackOut}, {31'd0, m_ack});
    end
    step();
    m_ack = ~m_ack; m_regs[a] = d; m_cpsr = c;
    check("ack_toggle", {31'd0, ackOut}, {31'd0, m_ack});
    check("pcwrite_commit", {31'd0, pcWriteOut}, {31'd0, (a == 4'd15)});
    check("cpsr", cpsrOut, m_cpsr);
    check("pc", pcOut, m_regs[15]);
    step();
    check("pcwrite_drop", {31'd0, pcWriteOut}, 32'd0);
    check("busy_idle", {31'd0, busyOut}, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_col;
    model_reset();

    // 1: reset for two edges, then release and read everything back.
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    check("rst_ack", {31'd0, ackOut}, 32'd0);
    check("rst_busy", {31'd0, busyOut}, 32'd0);
    check("rst_cpsr", cpsrOut, 32'h000000D3);
    check("rst_rdvalid", {31'd0, rdValid}, 32'd0);
    check("rst_pcwrite", {31'd0, pcWriteOut}, 32'd0);
    for (int i = 0; i < 8; i++) do_read(4'(i), 4'(15 - i));

    // 2: basic write to r3.
    do_write(4'd3, 32'hDEADBEEF, 32'h60000010);
    do_read(4'd3, 4'd3);

    // 3: PC write.
    do_write(4'd15, 32'h00008000, 32'h60000010);
    check("pc_value", pcOut, 32'h00008000);

    // 4: read/write collision on r5.
    do_write(4'd5, 32'h1, 32'h10);
    addrIn = 4'd5; dataIn = 32'h2; cpsrIn = 32'h20;
    triggerIn = ~triggerIn;
    step();
    step();
    step();
    rdEn = 1'b1; rdAddr1 = 4'd5; rdAddr2 = 4'd0;
    step();
    rdEn = 1'b0;
`ifdef REGBANK_WR_BYPASS_EN
    exp_col = 32'h2;
`else
    exp_col = 32'h1;
`endif
    m_ack = ~m_ack; m_regs[5] = 32'h2; m_cpsr = 32'h20;
    check("collide_valid", {31'd0, rdValid}, 32'd1);
    check("collide_rd1", rdData1, exp_col);
    check("collide_ack", {31'd0, ackOut}, {31'd0, m_ack});
    step();
    do_read(4'd5, 4'd5);

    // 5: second toggle while the first request is in CAPTURE.
    addrIn = 4'd6; dataIn = 32'hA; cpsrIn = 32'h30;
    triggerIn = ~triggerIn;
    step();
    step();
    step();
    check("b2b_busy", {31'd0, busyOut}, 32'd1);
    addrIn = 4'd7; dataIn = 32'hB; cpsrIn = 32'h40;
    triggerIn = ~triggerIn;
    step();
    m_ack = ~m_ack; m_regs[6] = 32'hA;
    check("b2b_ack1", {31'd0, ackOut}, {31'd0, m_ack});
    check("b2b_r7_old", {31'd0, (dut.regs_q[7] === 32'hB)}, 32'd0);
    step();
    step();
    check("b2b_ack_hold", {31'd0, ackOut}, {31'd0, m_ack});
    step();
    m_ack = ~m_ack; m_regs[7] = 32'hB; m_cpsr = 32'h40;
    check("b2b_ack2", {31'd0, ackOut}, {31'd0, m_ack});
    check("b2b_cpsr", cpsrOut, m_cpsr);
    step();
    do_read(4'd6, 4'd7);

    // 6: reset while in CAPTURE discards the write.
    addrIn = 4'd9; dataIn = 32'h55; cpsrIn = 32'h50;
    triggerIn = ~triggerIn;
    step();
    step();
    step();
    check("rstmid_busy", {31'd0, busyOut}, 32'd1);
    reset = 1'b0;
    triggerIn = 1'b0;
    step();
    reset = 1'b1;
    model_reset();
    check("rstmid_ack", {31'd0, ackOut}, 32'd0);
    check("rstmid_busy_idle", {31'd0, busyOut}, 32'd0);
    for (int i = 0; i < 6; i++) step();
    check("rstmid_ack_quiet", {31'd0, ackOut}, 32'd0);
    check("rstmid_cpsr", cpsrOut, 32'h000000D3);
    do_read(4'd9, 4'd3);

    // Randomized writes and reads against the model.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_write(4'($urandom_range(0, 15)), $urandom, $urandom);
      end else begin
        do_read(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
    end
    for (int i = 0; i < 16; i++) do_read(4'(i), 4'(i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
